// File: rtl/instr_issue_scheduler.sv
// In-order issue controller for the ESM datapath: decodes RegWrite/ALUSrc, tracks in-flight
// destinations in a shift-register scoreboard and inserts NOP bubbles on RAW hazards.
module instr_issue_scheduler #(
    parameter int unsigned PIPE_DEPTH = 3,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic [31:0] Instr_out,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        illegal,
    output logic [15:0] stall_cnt
);

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       dec_rw, dec_alusrc, dec_ill, use_rs1, use_rs2;
    logic       hazard, accept;

    logic        sb_v_q  [PIPE_DEPTH];
    logic        sb_v_d  [PIPE_DEPTH];
    logic [4:0]  sb_rd_q [PIPE_DEPTH];
    logic [4:0]  sb_rd_d [PIPE_DEPTH];

    logic [31:0] instr_q, instr_d;
    logic        rw_q, rw_d, alusrc_q, alusrc_d, ill_q, ill_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];

    always_comb begin
        dec_rw     = 1'b0;
        dec_alusrc = 1'b0;
        dec_ill    = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        unique case (opcode)
            7'b0110011: begin dec_rw = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            7'b0010011: begin dec_rw = 1'b1; dec_alusrc = 1'b1; use_rs1 = 1'b1; end
            7'b0000011: begin dec_rw = 1'b1; dec_alusrc = 1'b1; use_rs1 = 1'b1; end
            7'b0100011: begin dec_alusrc = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            default:    dec_ill = 1'b1;
        endcase
    end

    // x0 is never recorded, so a source of x0 can never match a valid entry with rd=0 anyway;
    // the explicit rsN != 0 terms keep that guarantee independent of the shift-in policy.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            if (sb_v_q[i] && ((use_rs1 && rs1 != 5'd0 && rs1 == sb_rd_q[i]) ||
                              (use_rs2 && rs2 != 5'd0 && rs2 == sb_rd_q[i]))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && in_valid;
    end

    assign in_ready = rst && !flush && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sb_v_d[0]  = 1'b0;
        sb_rd_d[0] = 5'd0;
        for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
            sb_v_d[i]  = sb_v_q[i-1];
            sb_rd_d[i] = sb_rd_q[i-1];
        end
        instr_d     = NOP_INSTR;
        rw_d        = 1'b0;
        alusrc_d    = 1'b0;
        ill_d       = 1'b0;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                sb_v_d[i] = 1'b0;
            end
        end else if (accept) begin
            sb_v_d[0]  = dec_rw && (rd != 5'd0);
            sb_rd_d[0] = rd;
            instr_d    = in_instr;
            rw_d       = dec_rw;
            alusrc_d   = dec_alusrc;
            ill_d      = dec_ill;
        end else if (hazard) begin
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q     <= NOP_INSTR;
            rw_q        <= 1'b0;
            alusrc_q    <= 1'b0;
            ill_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                sb_v_q[i]  <= 1'b0;
                sb_rd_q[i] <= 5'd0;
            end
        end else begin
            instr_q     <= instr_d;
            rw_q        <= rw_d;
            alusrc_q    <= alusrc_d;
            ill_q       <= ill_d;
            stall_cnt_q <= stall_cnt_d;
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
                sb_v_q[i]  <= sb_v_d[i];
                sb_rd_q[i] <= sb_rd_d[i];
            end
        end
    end

    assign Instr_out = instr_q;
    assign RegWrite  = rw_q;
    assign ALUSrc    = alusrc_q;
    assign illegal   = ill_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_instr_issue_scheduler.sv
// Scoreboard bench for instr_issue_scheduler: directed per-cycle vectors with hand-computed
// expectations; a monitor checks in_ready mid-cycle and the registered outputs after each edge.
module tb_instr_issue_scheduler;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic [31:0] Instr_out;
    logic        RegWrite;
    logic        ALUSrc;
    logic        illegal;
    logic [15:0] stall_cnt;

    instr_issue_scheduler #(
        .PIPE_DEPTH(3),
        .NOP_INSTR (NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .flush    (flush),
        .Instr_out(Instr_out),
        .RegWrite (RegWrite),
        .ALUSrc   (ALUSrc),
        .illegal  (illegal),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] instr;
        logic        flush;
        logic        rdy;
        logic [31:0] out;
        logic        rw;
        logic        as;
        logic        ill;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    vec_t q_exp[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic v, input logic [31:0] ins, input logic f,
                       input logic rdy, input logic [31:0] o, input logic rw, input logic as,
                       input logic ill, input logic [15:0] cnt);
        vec_t t;
        t.rst = r; t.valid = v; t.instr = ins; t.flush = f; t.rdy = rdy;
        t.out = o; t.rw = rw; t.as = as; t.ill = ill; t.cnt = cnt;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: in_ready for the vector currently driven, then outputs after the following edge.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk("in_ready", {31'd0, in_ready}, {31'd0, e.rdy});
                @(posedge clk);
                #2;
                chk("Instr_out", Instr_out, e.out);
                chk("RegWrite", {31'd0, RegWrite}, {31'd0, e.rw});
                chk("ALUSrc", {31'd0, ALUSrc}, {31'd0, e.as});
                chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.cnt});
            end
        end
    end

    initial begin
        rst      = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h0020_0393;
        flush    = 1'b0;

        //  rst valid instr         flush rdy out           rw    as    ill   cnt
        // Reset with valid held high
        add(0, 1, 32'h0020_0393, 0, 0, NOP,           0, 0, 0, 16'd0);
        add(0, 1, 32'h0020_0393, 0, 0, NOP,           0, 0, 0, 16'd0);
        // Independent stream
        add(1, 1, 32'h0020_0393, 0, 1, 32'h0020_0393, 1, 1, 0, 16'd0);
        add(1, 1, 32'h0050_0413, 0, 1, 32'h0050_0413, 1, 1, 0, 16'd0);
        // add x9,x7,x8: x8 in sb[0] limits to 3 bubbles
        add(1, 1, 32'h0083_84B3, 0, 0, NOP,           0, 0, 0, 16'd1);
        add(1, 1, 32'h0083_84B3, 0, 0, NOP,           0, 0, 0, 16'd2);
        add(1, 1, 32'h0083_84B3, 0, 0, NOP,           0, 0, 0, 16'd3);
        add(1, 1, 32'h0083_84B3, 0, 1, 32'h0083_84B3, 1, 0, 0, 16'd3);
        // Unsupported opcode, then idle: illegal is a single-cycle pulse
        add(1, 1, 32'h0012_2053, 0, 1, 32'h0012_2053, 0, 0, 1, 16'd3);
        add(1, 0, 32'h0012_2053, 0, 1, NOP,           0, 0, 0, 16'd3);
        // Back-to-back RAW on x1
        add(1, 1, 32'h0010_0093, 0, 1, 32'h0010_0093, 1, 1, 0, 16'd3);
        add(1, 1, 32'hFFF0_8093, 0, 0, NOP,           0, 0, 0, 16'd4);
        add(1, 1, 32'hFFF0_8093, 0, 0, NOP,           0, 0, 0, 16'd5);
        add(1, 1, 32'hFFF0_8093, 0, 0, NOP,           0, 0, 0, 16'd6);
        add(1, 1, 32'hFFF0_8093, 0, 1, 32'hFFF0_8093, 1, 1, 0, 16'd6);
        // Flush during the second bubble: +2 stalls only
        add(1, 1, 32'h0010_0093, 0, 1, 32'h0010_0093, 1, 1, 0, 16'd6);
        add(1, 1, 32'hFFF0_8093, 0, 0, NOP,           0, 0, 0, 16'd7);
        add(1, 1, 32'hFFF0_8093, 0, 0, NOP,           0, 0, 0, 16'd8);
        add(1, 1, 32'hFFF0_8093, 1, 0, NOP,           0, 0, 0, 16'd8);
        add(1, 1, 32'hFFF0_8093, 0, 1, 32'hFFF0_8093, 1, 1, 0, 16'd8);
        // Flush without hazard blocks the accept
        add(1, 1, 32'h0020_0393, 1, 0, NOP,           0, 0, 0, 16'd8);
        add(1, 1, 32'h0020_0393, 0, 1, 32'h0020_0393, 1, 1, 0, 16'd8);
        // Reset mid-stall (addi x7,x7,1), then held instruction accepted
        add(1, 1, 32'h0013_8393, 0, 0, NOP,           0, 0, 0, 16'd9);
        add(0, 1, 32'h0013_8393, 0, 0, NOP,           0, 0, 0, 16'd0);
        add(1, 1, 32'h0013_8393, 0, 1, 32'h0013_8393, 1, 1, 0, 16'd0);
        // Store sw x6,0(x2): no hazard; then sw x7,0(x0) hazards on rs2 (x7 in sb[1])
        add(1, 1, 32'h0061_2023, 0, 1, 32'h0061_2023, 0, 1, 0, 16'd0);
        add(1, 1, 32'h0070_2023, 0, 0, NOP,           0, 0, 0, 16'd1);
        add(1, 1, 32'h0070_2023, 0, 0, NOP,           0, 0, 0, 16'd2);
        add(1, 1, 32'h0070_2023, 0, 1, 32'h0070_2023, 0, 1, 0, 16'd2);
        add(1, 0, 32'h0000_0000, 0, 1, NOP,           0, 0, 0, 16'd2);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst      = vecs[i].rst;
            in_valid = vecs[i].valid;
            in_instr = vecs[i].instr;
            flush    = vecs[i].flush;
            q_exp.push_back(vecs[i]);
        end

        for (int n = 0; n < 20 && q_exp.size() > 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_issue_scheduler.md
Name: instr_issue_scheduler

Overview:
- In-order issue controller in front of the ESM datapath.
- Accepts RV32 instructions over a valid/ready handshake and decodes the ESM control inputs (RegWrite, ALUSrc).
- Tracks destination registers still in flight in a shift-register scoreboard.
- Inserts NOP bubbles (addi x0,x0,0) on read-after-write hazards, so ESM receives exactly one instruction per clock.

Parameters:
- PIPE_DEPTH, 3: cycles after issue during which a written rd is unavailable; also the scoreboard depth (1..8).
- NOP_INSTR, 32'h00000013: bubble instruction driven on stall, idle, flush and reset.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_instr  in  32  upstream RV32 instruction.
- in_ready  out  1  combinational; high when in_instr is accepted this cycle.
- flush  in  1  synchronous pipeline flush.
- Instr_out  out  32  registered instruction to ESM.
- RegWrite  out  1  registered; ESM register-write enable for Instr_out.
- ALUSrc  out  1  registered; ESM ALU operand select for Instr_out (1 = immediate).
- illegal  out  1  registered one-cycle pulse: issued instruction has an unsupported opcode.
- stall_cnt  out  16  saturating count of hazard-bubble cycles.

Behaviour:
- Decode of in_instr, by opcode [6:0]:
  - 0110011 R-type: RegWrite=1, ALUSrc=0; sources rs1, rs2.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1; source rs1.
  - 0000011 load: RegWrite=1, ALUSrc=1; source rs1.
  - 0100011 store: RegWrite=0, ALUSrc=1; sources rs1, rs2.
  - Any other opcode: RegWrite=0, ALUSrc=0, no sources, illegal=1.
- Field positions: rd=[11:7], rs1=[19:15], rs2=[24:20].
- Scoreboard: PIPE_DEPTH entries of {v, rd}; sb[0] is the newest.
  - Shifts every cycle: sb[i+1] <= sb[i]; the oldest entry drops out.
  - sb[0] <= {RegWrite_dec && rd!=0, rd} on accept; {0, 0} otherwise.
- Hazard (combinational) = in_valid && some used source rsN != 0 && rsN == sb[i].rd with sb[i].v, for any i.
- Handshake: in_ready = rst && !flush && !hazard.
  - Accept when in_valid && in_ready.
  - When in_valid && !in_ready, upstream holds in_instr stable.
- Per-cycle update, in priority order:
  - !rst: Instr_out=NOP_INSTR, RegWrite=0, ALUSrc=0, illegal=0, stall_cnt=0, all sb.v=0.
  - flush: Instr_out=NOP_INSTR, controls=0, all sb.v cleared (no shift-in); stall_cnt unchanged; no accept.
  - accept: Instr_out=in_instr, RegWrite/ALUSrc/illegal from decode, scoreboard shifts in rd.
  - hazard: Instr_out=NOP_INSTR, controls=0, scoreboard shifts in empty entry, stall_cnt+1 (saturates at 16'hFFFF).
  - idle (!in_valid): as hazard, but stall_cnt unchanged.
- Latency: accepted instruction appears on Instr_out at the next rising edge.
- A dependent instruction directly after its producer receives exactly PIPE_DEPTH bubbles.
- rd=x0 is never recorded; rs=x0 never causes a hazard.
- Reset or flush mid-stall drops the stall; the held instruction is re-evaluated against the cleared scoreboard next cycle and accepted if in_valid.

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid=1 -> Instr_out=32'h00000013, RegWrite=0, ALUSrc=0, in_ready=0, stall_cnt=0.
- Independent stream: 32'h00200393 (addi x7,x0,2) then 32'h00500413 (addi x8,x0,5) back-to-back -> both accepted on consecutive edges; outputs RegWrite=1, ALUSrc=1; stall_cnt=0.
- Back-to-back RAW: 32'h00100093 (addi x1,x0,1) then 32'hFFF08093 (addi x1,x1,-1) -> Instr_out shows 00100093, three NOPs, then FFF08093; in_ready low exactly 3 cycles; stall_cnt=3.
- Partial-distance RAW: x7/x8 producers above, then 32'h008384B3 (add x9,x7,x8) -> 3 bubbles (limited by x8 in sb[0]); issued with RegWrite=1, ALUSrc=0.
- Unsupported opcode: 32'h00122053 -> issued unchanged next cycle; RegWrite=0, ALUSrc=0, illegal pulses one cycle; no stall.
- Flush mid-stall: during the second bubble of the back-to-back RAW case, assert flush one cycle -> NOP that cycle; FFF08093 accepted on the following edge; stall_cnt=2.
